// File: rtl/blink_rate_controller.sv
// Run/pause/stop sequencer for a free-running timebase with a REQ/ACK run-time period update.
// Latency: ACK/REJECT/PEND/STATE/COUNT are registered; TICK and BLINK are decoded from registers.
// Backpressure: REQ is held until ACK or REJECT; a held REQ is re-armed only after it drops.
module blink_rate_controller #(
  parameter int          N              = 26,
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter int unsigned MIN_PERIOD     = 2
) (
  input  logic         CLKb,
  input  logic         CLRb,
  input  logic         START,
  input  logic         STOP,
  input  logic         REQ,
  input  logic [N-1:0] PERIOD_IN,
  output logic         ACK,
  output logic         REJECT,
  output logic         PEND,
  output logic [1:0]   STATE,
  output logic [N-1:0] COUNT,
  output logic         TICK,
  output logic         BLINK,
  output logic         TOGGLE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  localparam logic [N-1:0] DEF_P = N'(DEFAULT_PERIOD);
  localparam logic [N-1:0] MIN_P = N'(MIN_PERIOD);

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] period_q, shadow_q;
  logic         pend_q, ack_q, reject_q, toggle_q, armed_q;
  logic         tick, capture, bad_req, install;

  assign tick    = (state_q == S_RUN) && (count_q == period_q - 1'b1);
  assign capture = REQ && armed_q && !pend_q && !ack_q && !reject_q;
  assign bad_req = PERIOD_IN < MIN_P;
  // In RUN the new period waits for the wrap so the current period always completes.
  assign install = pend_q && ((state_q != S_RUN) || tick);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (START && !STOP) state_d = S_RUN;
        count_d = '0;
      end
      S_RUN: begin
        if (STOP) state_d = S_PAUSE;
        count_d = tick ? '0 : count_q + 1'b1;
      end
      S_PAUSE: begin
        if (STOP) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (START) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    if (install) count_d = '0;
  end

  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      period_q <= DEF_P;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      reject_q <= 1'b0;
      toggle_q <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ack_q    <= install;
      reject_q <= capture && bad_req;
      if (tick) toggle_q <= ~toggle_q;
      if (install) begin
        period_q <= shadow_q;
        pend_q   <= 1'b0;
      end else if (capture && !bad_req) begin
        shadow_q <= PERIOD_IN;
        pend_q   <= 1'b1;
      end
      if (capture)   armed_q <= 1'b0;
      else if (!REQ) armed_q <= 1'b1;
    end
  end

  assign ACK    = ack_q;
  assign REJECT = reject_q;
  assign PEND   = pend_q;
  assign STATE  = state_q;
  assign COUNT  = count_q;
  assign TICK   = tick;
  assign BLINK  = (state_q != S_IDLE) && (count_q >= (period_q >> 1));
  assign TOGGLE = toggle_q;

endmodule

// File: tb/tb_blink_rate_controller.sv
// Directed bench for blink_rate_controller with a 10-clock default period.
module tb_blink_rate_controller;

  localparam int N = 26;

  logic         CLKb = 1'b0;
  logic         CLRb = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         REQ = 1'b0;
  logic [N-1:0] PERIOD_IN = '0;
  logic         ACK, REJECT, PEND, TICK, BLINK, TOGGLE;
  logic [1:0]   STATE;
  logic [N-1:0] COUNT;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int exp_tog = 0;
  int obs_ticks = 0;

  blink_rate_controller #(.N(N), .DEFAULT_PERIOD(10), .MIN_PERIOD(2)) dut (
    .CLKb(CLKb), .CLRb(CLRb), .START(START), .STOP(STOP), .REQ(REQ),
    .PERIOD_IN(PERIOD_IN), .ACK(ACK), .REJECT(REJECT), .PEND(PEND),
    .STATE(STATE), .COUNT(COUNT), .TICK(TICK), .BLINK(BLINK), .TOGGLE(TOGGLE)
  );

  always #5 CLKb = ~CLKb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKb);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"},  32'(STATE),  0);
    chk({tag, "_count"},  32'(COUNT),  0);
    chk({tag, "_blink"},  32'(BLINK),  0);
    chk({tag, "_toggle"}, 32'(TOGGLE), 0);
    chk({tag, "_tick"},   32'(TICK),   0);
    chk({tag, "_ack"},    32'(ACK),    0);
    chk({tag, "_reject"}, 32'(REJECT), 0);
    chk({tag, "_pend"},   32'(PEND),   0);
  endtask

  // Free-running expectation while in RUN with period p.
  task automatic run_check(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      chk("run_count", 32'(COUNT), 32'(exp_cnt));
      chk("run_tick",  32'(TICK),  32'(exp_cnt == p - 1));
      chk("run_blink", 32'(BLINK), 32'(exp_cnt >= p / 2));
      obs_ticks += int'(TICK);
      if (exp_cnt == p - 1) exp_tog ^= 1;
      step();
      exp_cnt = (exp_cnt + 1) % p;
      chk("run_toggle", 32'(TOGGLE), 32'(exp_tog));
    end
  endtask

  initial begin
    // 1. reset
    #3;
    check_reset("rst");
    step();
    CLRb = 1'b1;
    step();
    chk("idle_state", 32'(STATE), 0);

    // 2. run 40 cycles at P=10
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_state", 32'(STATE), 1);
    exp_cnt = 0; exp_tog = 0; obs_ticks = 0;
    run_check(40, 10);
    chk("ticks_in_40", 32'(obs_ticks), 4);
    chk("toggle_after_40", 32'(TOGGLE), 0);

    // 3. period change to 4 during RUN
    run_check(3, 10);
    REQ = 1'b1; PERIOD_IN = 26'd4;
    run_check(1, 10);
    chk("req4_pend", 32'(PEND), 1);
    repeat (5) begin
      chk("req4_pend_hold", 32'(PEND), 1);
      chk("req4_no_ack", 32'(ACK), 0);
      run_check(1, 10);
    end
    chk("req4_pend_last", 32'(PEND), 1);
    run_check(1, 10);
    chk("req4_ack", 32'(ACK), 1);
    chk("req4_pend_clr", 32'(PEND), 0);
    run_check(1, 4);
    chk("req4_ack_once", 32'(ACK), 0);
    chk("req4_no_recapture", 32'(PEND), 0);
    REQ = 1'b0;
    run_check(11, 4);

    // 4. rejected request, then install in IDLE
    REQ = 1'b1; PERIOD_IN = 26'd1;
    run_check(1, 4);
    chk("rej_pulse", 32'(REJECT), 1);
    chk("rej_pend", 32'(PEND), 0);
    run_check(2, 4);
    chk("rej_once", 32'(REJECT), 0);
    chk("rej_no_pend", 32'(PEND), 0);
    chk("rej_no_ack", 32'(ACK), 0);
    REQ = 1'b0;
    run_check(6, 4);
    STOP = 1'b1;
    step();
    chk("stop1_state", 32'(STATE), 2);
    chk("stop1_count", 32'(COUNT), 2);
    step();
    STOP = 1'b0;
    chk("stop2_state", 32'(STATE), 0);
    chk("stop2_count", 32'(COUNT), 0);
    chk("stop2_blink", 32'(BLINK), 0);
    REQ = 1'b1; PERIOD_IN = 26'd6;
    step();
    chk("idle6_pend", 32'(PEND), 1);
    chk("idle6_no_ack", 32'(ACK), 0);
    step();
    chk("idle6_ack", 32'(ACK), 1);
    chk("idle6_pend_clr", 32'(PEND), 0);
    REQ = 1'b0;
    step();
    chk("idle6_ack_once", 32'(ACK), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    exp_cnt = 0;
    run_check(12, 6);
    STOP = 1'b1;
    step();
    step();
    STOP = 1'b0;
    chk("back_idle", 32'(STATE), 0);
    REQ = 1'b1; PERIOD_IN = 26'd10;
    step();
    step();
    chk("idle10_ack", 32'(ACK), 1);
    REQ = 1'b0;
    step();

    // 5. pause / resume / stop
    START = 1'b1;
    step();
    START = 1'b0;
    exp_cnt = 0;
    run_check(6, 10);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("pause_state", 32'(STATE), 2);
    chk("pause_count", 32'(COUNT), 7);
    chk("pause_blink", 32'(BLINK), 1);
    repeat (3) step();
    chk("pause_hold_count", 32'(COUNT), 7);
    chk("pause_hold_blink", 32'(BLINK), 1);
    chk("pause_no_tick", 32'(TICK), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("resume_state", 32'(STATE), 1);
    step();
    chk("resume_count", 32'(COUNT), 8);
    START = 1'b1; STOP = 1'b1;
    step();
    START = 1'b0; STOP = 1'b0;
    chk("both_state", 32'(STATE), 2);
    step();
    chk("both_hold_count", 32'(COUNT), 9);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk("final_stop_state", 32'(STATE), 0);
    chk("final_stop_count", 32'(COUNT), 0);
    chk("final_stop_blink", 32'(BLINK), 0);
    chk("final_stop_toggle", 32'(TOGGLE), 32'(exp_tog));

    // 6. asynchronous reset with a pending request
    START = 1'b1;
    step();
    START = 1'b0;
    exp_cnt = 0;
    run_check(2, 10);
    REQ = 1'b1; PERIOD_IN = 26'd3;
    run_check(1, 10);
    chk("pre_rst_pend", 32'(PEND), 1);
    run_check(2, 10);
    chk("pre_rst_count", 32'(COUNT), 5);
    #2;
    CLRb = 1'b0;
    #1;
    check_reset("arst");
    REQ = 1'b0;
    #2;
    CLRb = 1'b1;
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    exp_cnt = 0; exp_tog = 0;
    run_check(12, 10);
    chk("post_rst_pend", 32'(PEND), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
